// File: rtl/anim_frame_sequencer.sv
// Sprite animation frame sequencer driving an external up speed counter (clear/count-enable).
// Optional build macro ANIMSEQ_PAUSE_EN adds an active-low pause input that freezes the counter in RUN.
module anim_frame_sequencer #(
   parameter int COUNT_WIDTH = 24,
   parameter int FRAME_TICKS = 2_500_000,
   parameter int NUM_FRAMES  = 4,
   parameter int FRAME_WIDTH = 2
) (
   input  logic                   SC_ANIMSEQ_CLOCK_50,
   input  logic                   SC_ANIMSEQ_RESET_InHigh,
   input  logic                   SC_ANIMSEQ_start_InLow,
   input  logic [1:0]             SC_ANIMSEQ_dir_InBUS,
   input  logic [COUNT_WIDTH-1:0] SC_ANIMSEQ_count_InBUS,
`ifdef ANIMSEQ_PAUSE_EN
   input  logic                   SC_ANIMSEQ_pause_InLow,
`endif
   output logic                   SC_ANIMSEQ_cntClear_Out,
   output logic                   SC_ANIMSEQ_cntUpcount_OutLow,
   output logic [FRAME_WIDTH-1:0] SC_ANIMSEQ_frame_OutBUS,
   output logic [1:0]             SC_ANIMSEQ_dir_OutBUS,
   output logic                   SC_ANIMSEQ_busy_Out,
   output logic                   SC_ANIMSEQ_done_Out
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ARM    = 2'd1;
   localparam logic [1:0] ST_RUN    = 2'd2;
   localparam logic [1:0] ST_FINISH = 2'd3;

   localparam logic [COUNT_WIDTH-1:0] HIT_LEVEL  = COUNT_WIDTH'(FRAME_TICKS - 1);
   localparam logic [FRAME_WIDTH-1:0] LAST_FRAME = FRAME_WIDTH'(NUM_FRAMES - 1);

   logic                   clk;
   logic                   rst;
   logic                   pause_n;

   logic [1:0]             state_q, state_d;
   logic                   start_q;
   logic                   clr_q, clr_d;
   logic                   upn_q, upn_d;
   logic [FRAME_WIDTH-1:0] frame_q, frame_d;
   logic [1:0]             dir_q, dir_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;

   logic                   start_fall;
   logic                   frame_hit;

   assign clk = SC_ANIMSEQ_CLOCK_50;
   assign rst = SC_ANIMSEQ_RESET_InHigh;

`ifdef ANIMSEQ_PAUSE_EN
   assign pause_n = SC_ANIMSEQ_pause_InLow;
`else
   assign pause_n = 1'b1;
`endif

   assign start_fall = start_q & ~SC_ANIMSEQ_start_InLow;

   // A hit is only trusted once the clear pulse has dropped, so the stale pre-clear value is ignored.
   assign frame_hit  = ~clr_q & pause_n & (SC_ANIMSEQ_count_InBUS >= HIT_LEVEL);

   // Outputs are decoded from the next state so every output leaves a flop.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
      state_d = state_q;
      frame_d = frame_q;
      dir_d   = dir_q;
      clr_d   = 1'b1;
      upn_d   = 1'b1;
      busy_d  = 1'b0;
      done_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            frame_d = '0;
            if (start_fall) begin
               state_d = ST_ARM;
               dir_d   = SC_ANIMSEQ_dir_InBUS;
               busy_d  = 1'b1;
               upn_d   = 1'b0;
            end
         end

         ST_ARM: begin
            state_d = ST_RUN;
            busy_d  = 1'b1;
            clr_d   = 1'b0;
            upn_d   = ~pause_n;
         end

         ST_RUN: begin
            busy_d = 1'b1;
            clr_d  = 1'b0;
            upn_d  = ~pause_n;
            if (frame_hit) begin
               if (frame_q == LAST_FRAME) begin
                  state_d = ST_FINISH;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  clr_d   = 1'b1;
                  upn_d   = 1'b1;
               end else begin
                  frame_d = frame_q + FRAME_WIDTH'(1);
                  clr_d   = 1'b1;
               end
            end
         end

         ST_FINISH: begin
            state_d = ST_IDLE;
            frame_d = '0;
         end

         default: begin
            state_d = ST_IDLE;
            frame_d = '0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         start_q <= 1'b1;
         clr_q   <= 1'b1;
         upn_q   <= 1'b1;
         frame_q <= '0;
         dir_q   <= 2'b00;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= SC_ANIMSEQ_start_InLow;
         clr_q   <= clr_d;
         upn_q   <= upn_d;
         frame_q <= frame_d;
         dir_q   <= dir_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign SC_ANIMSEQ_cntClear_Out      = clr_q;
   assign SC_ANIMSEQ_cntUpcount_OutLow = upn_q;
   assign SC_ANIMSEQ_frame_OutBUS      = frame_q;
   assign SC_ANIMSEQ_dir_OutBUS        = dir_q;
   assign SC_ANIMSEQ_busy_Out          = busy_q;
   assign SC_ANIMSEQ_done_Out          = done_q;

endmodule
